// File: rtl/step_seq_if.sv
// Command/completion bus of step_seq: command strobe, read port, completion
// pulse and sweep status, plus a debug view of the sweep FSM state.
interface step_seq_if #(
   parameter int WIDTH    = 2,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   // Handshake: a command is taken on the rising edge where en=1 and busy=0;
   // there is no backpressure beyond busy. out_valid is a one-cycle pulse in
   // the cycle after acceptance and qualifies out_ch/out_val/wrap/err.
   logic             en;
   logic [SEL_W-1:0] ch_sel;
   logic [1:0]       mode;
   logic [WIDTH-1:0] load_val;
   logic             clr_all;
   logic [SEL_W-1:0] rd_sel;
   logic [WIDTH-1:0] rd_val;
   logic             out_valid;
   logic [SEL_W-1:0] out_ch;
   logic [WIDTH-1:0] out_val;
   logic             wrap;
   logic             err;
   logic             busy;
   logic             state_dbg;

   modport master (
      output en, ch_sel, mode, load_val, clr_all, rd_sel,
      input  rd_val, out_valid, out_ch, out_val, wrap, err, busy, state_dbg
   );

   modport slave (
      input  en, ch_sel, mode, load_val, clr_all, rd_sel,
      output rd_val, out_valid, out_ch, out_val, wrap, err, busy, state_dbg
   );
endinterface

// File: rtl/step_seq.sv
// Bank of CHANNELS step counters (INC/DEC/LOAD/CLEAR) with a clear-all sweep FSM.
// Define STEP_SEQ_SATURATE_EN to make INC/DEC saturate instead of wrapping.
module step_seq #(
   parameter int WIDTH    = 2,
   parameter int CHANNELS = 4,
   parameter int LIMIT    = 2**WIDTH-1
) (
   input logic       clk,
   input logic       rst_n,
   step_seq_if.slave bus
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
   localparam logic [1:0] MODE_INC   = 2'b00;
   localparam logic [1:0] MODE_DEC   = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_CLEAR = 2'b11;

   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] sweep_idx, sweep_idx_nxt;
   logic [WIDTH-1:0] cnt [CHANNELS];
   logic [WIDTH-1:0] cur, upd, rd_mux;
   logic             upd_wrap, accept, ch_ok, sweep_last;

   assign accept     = bus.en && (state == IDLE);
   assign ch_ok      = int'(bus.ch_sel) < CHANNELS;
   assign sweep_last = int'(sweep_idx) == CHANNELS - 1;

   // Out-of-range selects fall through to zero.
   always_comb begin
      cur    = '0;
      rd_mux = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (int'(bus.ch_sel) == c) cur = cnt[c];
         if (int'(bus.rd_sel) == c) rd_mux = cnt[c];
      end
   end

   always_comb begin
      upd      = cur;
      upd_wrap = 1'b0;
      case (bus.mode)
         MODE_INC: begin
            if (cur == LIM) begin
`ifdef STEP_SEQ_SATURATE_EN
               upd = LIM;
`else
               upd      = '0;
               upd_wrap = 1'b1;
`endif
            end else begin
               upd = cur + WIDTH'(1);
            end
         end
         MODE_DEC: begin
            if (cur == '0) begin
`ifdef STEP_SEQ_SATURATE_EN
               upd = '0;
`else
               upd      = LIM;
               upd_wrap = 1'b1;
`endif
            end else begin
               upd = cur - WIDTH'(1);
            end
         end
         MODE_LOAD:  upd = (bus.load_val > LIM) ? LIM : bus.load_val;
         MODE_CLEAR: upd = '0;
         default:    upd = cur;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      sweep_idx_nxt = sweep_idx;
      case (state)
         IDLE: begin
            sweep_idx_nxt = '0;
            if (bus.clr_all) state_nxt = SWEEP;
         end
         SWEEP: begin
            if (sweep_last) begin
               state_nxt     = IDLE;
               sweep_idx_nxt = '0;
            end else begin
               sweep_idx_nxt = sweep_idx + SEL_W'(1);
            end
         end
         default: begin
            state_nxt     = IDLE;
            sweep_idx_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         sweep_idx     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_ch    <= '0;
         bus.out_val   <= '0;
         bus.wrap      <= 1'b0;
         bus.err       <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
      end else begin
         state         <= state_nxt;
         sweep_idx     <= sweep_idx_nxt;
         bus.out_valid <= accept;
         // Sweep and command writes never collide: commands are only taken in IDLE.
         for (int c = 0; c < CHANNELS; c++) begin
            if (state == SWEEP && int'(sweep_idx) == c)
               cnt[c] <= '0;
            else if (accept && ch_ok && int'(bus.ch_sel) == c)
               cnt[c] <= upd;
         end
         if (accept) begin
            bus.out_ch  <= bus.ch_sel;
            bus.out_val <= ch_ok ? upd : '0;
            bus.wrap    <= ch_ok & upd_wrap;
            bus.err     <= !ch_ok;
         end
      end
   end

   assign bus.rd_val    = rd_mux;
   assign bus.busy      = (state == SWEEP);
   assign bus.state_dbg = (state == SWEEP);
endmodule

// File: tb/tb_step_seq.sv
// Directed bench for step_seq: default build (4 ch, LIMIT 3) and a 3-channel,
// LIMIT 2 instance for clamping and out-of-range channel handling.
module tb_step_seq;
   localparam logic [1:0] INC = 2'b00, DEC = 2'b01, LOAD = 2'b10, CLR = 2'b11;
`ifdef STEP_SEQ_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   step_seq_if #(.WIDTH(2), .CHANNELS(4)) a_if ();
   step_seq_if #(.WIDTH(2), .CHANNELS(3)) b_if ();

   step_seq #(.WIDTH(2), .CHANNELS(4), .LIMIT(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
   );
   step_seq #(.WIDTH(2), .CHANNELS(3), .LIMIT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic a_cmd(input int ch, input logic [1:0] md, input int lv, input logic clr);
      a_if.ch_sel   = 2'(ch);
      a_if.mode     = md;
      a_if.load_val = 2'(lv);
      a_if.clr_all  = clr;
      a_if.en       = 1'b1;
      tick();
      a_if.en      = 1'b0;
      a_if.clr_all = 1'b0;
   endtask

   task automatic b_cmd(input int ch, input logic [1:0] md, input int lv);
      b_if.ch_sel   = 2'(ch);
      b_if.mode     = md;
      b_if.load_val = 2'(lv);
      b_if.en       = 1'b1;
      tick();
      b_if.en = 1'b0;
   endtask

   task automatic a_done(input string tag, input int ch, input int val, input int wr);
      check({tag, "_valid"}, a_if.out_valid, 1);
      check({tag, "_ch"},    a_if.out_ch, ch);
      check({tag, "_val"},   a_if.out_val, val);
      check({tag, "_wrap"},  a_if.wrap, wr);
      check({tag, "_err"},   a_if.err, 0);
   endtask

   task automatic b_done(input string tag, input int ch, input int val, input int wr, input int er);
      check({tag, "_valid"}, b_if.out_valid, 1);
      check({tag, "_ch"},    b_if.out_ch, ch);
      check({tag, "_val"},   b_if.out_val, val);
      check({tag, "_wrap"},  b_if.wrap, wr);
      check({tag, "_err"},   b_if.err, er);
   endtask

   task automatic a_rd(input string tag, input int ch, input int exp);
      a_if.rd_sel = 2'(ch);
      #1;
      check(tag, a_if.rd_val, exp);
   endtask

   task automatic b_rd(input string tag, input int ch, input int exp);
      b_if.rd_sel = 2'(ch);
      #1;
      check(tag, b_if.rd_val, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      a_if.en = 1'b1; a_if.ch_sel = 2'd2; a_if.mode = INC; a_if.load_val = '0;
      a_if.clr_all = 1'b0; a_if.rd_sel = '0;
      b_if.en = 1'b0; b_if.ch_sel = '0; b_if.mode = INC; b_if.load_val = '0;
      b_if.clr_all = 1'b0; b_if.rd_sel = '0;

      // Reset holds everything at zero even with a command presented.
      tick();
      tick();
      a_if.en = 1'b0;
      check("rst_valid", a_if.out_valid, 0);
      check("rst_busy", a_if.busy, 0);
      check("rst_state", a_if.state_dbg, 0);
      check("rst_val", a_if.out_val, 0);
      for (int c = 0; c < 4; c++) a_rd($sformatf("rst_rd%0d", c), c, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", a_if.out_valid, 0);

      // Narrow instance: LOAD clamps to LIMIT=2, ch_sel=3 is rejected.
      b_cmd(1, LOAD, 3);
      b_done("b_load_clamp", 1, 2, 0, 0);
      b_cmd(1, INC, 0);
      b_done("b_inc_lim", 1, SAT ? 2 : 0, SAT ? 0 : 1, 0);
      b_cmd(2, LOAD, 1);
      b_done("b_load2", 2, 1, 0, 0);
      b_cmd(3, INC, 0);
      b_done("b_bad_inc", 3, 0, 0, 1);
      b_rd("b_rd0", 0, 0);
      b_rd("b_rd1", 1, SAT ? 2 : 0);
      b_rd("b_rd2", 2, 1);
      b_rd("b_rd3", 3, 0);
      b_cmd(3, LOAD, 2);
      b_done("b_bad_load", 3, 0, 0, 1);
      b_rd("b_rd2_after", 2, 1);

      // INC ch2 four times.
      if (SAT) begin exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd3); end
      else begin exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0); end
      for (int i = 0; i < 4; i++) begin
         a_cmd(2, INC, 0, 1'b0);
         a_done($sformatf("inc2_%0d", i), 2, int'(exp_q.pop_front()), (i == 3 && !SAT) ? 1 : 0);
      end
      tick();
      check("inc2_valid_drop", a_if.out_valid, 0);
      a_rd("inc2_rd", 2, SAT ? 3 : 0);
      a_cmd(2, CLR, 0, 1'b0);
      a_done("clr2", 2, 0, 0);

      // DEC from 0, then read-before-write on a same-cycle LOAD.
      a_cmd(0, DEC, 0, 1'b0);
      a_done("dec0", 0, SAT ? 0 : 3, SAT ? 0 : 1);
      a_if.ch_sel = 2'd0; a_if.mode = LOAD; a_if.load_val = 2'd2; a_if.en = 1'b1;
      a_rd("rd_before_load", 0, SAT ? 0 : 3);
      tick();
      a_if.en = 1'b0;
      a_done("load0", 0, 2, 0);
      a_rd("rd_after_load", 0, 2);
      a_cmd(0, DEC, 0, 1'b0);
      a_done("dec0_mid", 0, 1, 0);
      a_cmd(0, INC, 0, 1'b0);
      a_done("inc0_mid", 0, 2, 0);
      a_cmd(0, CLR, 0, 1'b0);
      a_done("clr0", 0, 0, 0);

      // Clear-all sweep with en and a repeated clr_all ignored while busy.
      for (int c = 0; c < 4; c++) begin
         a_cmd(c, LOAD, 3, 1'b0);
         a_done($sformatf("sw_load%0d", c), c, 3, 0);
      end
      a_if.clr_all = 1'b1;
      tick();
      a_if.clr_all = 1'b0;
      check("sw_state", a_if.state_dbg, 1);
      check("sw_valid0", a_if.out_valid, 0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("sw_busy%0d", k), a_if.busy, 1);
         a_if.ch_sel = 2'd1; a_if.mode = INC; a_if.en = 1'b1;
         a_if.clr_all = (k == 1);
         tick();
         a_if.en = 1'b0; a_if.clr_all = 1'b0;
         check($sformatf("sw_novalid%0d", k), a_if.out_valid, 0);
         a_rd($sformatf("sw_zero%0d", k), k, 0);
         if (k < 3) a_rd($sformatf("sw_keep%0d", k + 1), k + 1, 3);
      end
      check("sw_done_busy", a_if.busy, 0);
      tick();
      check("sw_no_restart", a_if.busy, 0);
      a_rd("sw_ch1_untouched", 1, 0);

      // Command and clr_all together: command completes, then the sweep runs.
      a_cmd(3, LOAD, 2, 1'b1);
      a_done("cmd_clr", 3, 2, 0);
      check("cmd_clr_busy", a_if.busy, 1);
      tick(); tick(); tick();
      a_rd("cmd_clr_ch3_pending", 3, 2);
      check("cmd_clr_busy3", a_if.busy, 1);
      tick();
      check("cmd_clr_busy_end", a_if.busy, 0);
      a_rd("cmd_clr_ch3", 3, 0);

      // Reset mid-sweep after two channels cleared.
      for (int c = 0; c < 4; c++) a_cmd(c, LOAD, 3, 1'b0);
      a_done("abort_load3", 3, 3, 0);
      a_if.clr_all = 1'b1;
      tick();
      a_if.clr_all = 1'b0;
      tick(); tick();
      a_rd("abort_ch1", 1, 0);
      a_rd("abort_ch2_pre", 2, 3);
      rst_n = 1'b0;
      a_if.ch_sel = 2'd2; a_if.mode = INC; a_if.en = 1'b1;
      tick();
      a_if.en = 1'b0;
      check("abort_busy", a_if.busy, 0);
      check("abort_valid", a_if.out_valid, 0);
      check("abort_out_ch", a_if.out_ch, 0);
      check("abort_out_val", a_if.out_val, 0);
      a_rd("abort_ch2", 2, 0);
      a_rd("abort_ch3", 3, 0);
      rst_n = 1'b1;
      a_cmd(3, LOAD, 1, 1'b0);
      a_done("abort_reload", 3, 1, 0);
      tick(); tick(); tick();
      check("abort_no_resume", a_if.busy, 0);
      a_rd("abort_ch3_kept", 3, 1);

      // INC ch3 five times from reset.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      if (SAT) begin exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd3); exp_q.push_back(2'd3); end
      else begin exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1); end
      for (int i = 0; i < 5; i++) begin
         a_cmd(3, INC, 0, 1'b0);
         a_done($sformatf("inc3_%0d", i), 3, int'(exp_q.pop_front()), (i == 3 && !SAT) ? 1 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
